idu_top: RTL and testbench

IDU_TOP -- requirements
Module: idu_top

---
 rtl/idu_top.sv | 226 ++++++++++++++++++++++
 tb/tb_idu_top.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/idu_top.sv
// RV32I instruction decode unit: captures one instruction word per Fetch_ready strobe
// and presents the registered decode one cycle later with a single-cycle IDU_ready pulse.
module idu_top (
  input  logic        soc_clk,
  input  logic        IDU_reset,
  input  logic        Fetch_ready,
  input  logic [31:0] instruction,
  input  logic        IDU_stall,
  output logic        IDU_ready,
  output logic [5:0]  Instruction_to_CU,
  output logic [4:0]  Instruction_to_ALU,
  output logic [31:0] imm,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  shamt,
  output logic [31:0] pc_increment,
  output logic [1:0]  pipeline_override,
  output logic        invalid_instruction,
  output logic        state_dbg
);

  localparam logic [4:0] ALU_ADD = 5'd0,  ALU_SUB = 5'd1,  ALU_SLL = 5'd2,  ALU_SLT = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4, ALU_XOR = 5'd5,  ALU_SRL = 5'd6,  ALU_SRA = 5'd7;
  localparam logic [4:0] ALU_OR = 5'd8,   ALU_AND = 5'd9,  ALU_EQ = 5'd10,  ALU_NE = 5'd11;
  localparam logic [4:0] ALU_LT = 5'd12,  ALU_GE = 5'd13,  ALU_LTU = 5'd14, ALU_GEU = 5'd15;
  localparam logic [4:0] ALU_PASSB = 5'd16, ALU_NOP = 5'd31;

  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OP = 7'b0110011;
  localparam logic [6:0] OPC_FENCE = 7'b0001111, OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000;

  // Handshake: Fetch_ready is a valid strobe with no backpressure; an instruction is taken on
  // any edge where Fetch_ready=1 and IDU_stall=0. IDU_stall is the only hold, freezing everything.
  typedef enum logic {ST_IDLE = 1'b0, ST_PENDING = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [31:0] inst_q;

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        ok;
  logic [5:0]  d_cu;
  logic [4:0]  d_alu, d_rd, d_rs1, d_rs2, d_shamt;
  logic [31:0] d_imm, d_pc;
  logic [1:0]  d_ovr;

  assign opc   = inst_q[6:0];
  assign f3    = inst_q[14:12];
  assign f7    = inst_q[31:25];
  assign imm_i = {{20{inst_q[31]}}, inst_q[31:20]};
  assign imm_s = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
  assign imm_b = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
  assign imm_u = {inst_q[31:12], 12'b0};
  assign imm_j = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};

  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    if (!IDU_stall) state_nxt = Fetch_ready ? ST_PENDING : ST_IDLE;
  end

  always_ff @(posedge soc_clk) begin
    if (IDU_reset) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // Fields are filled freely per opcode; the final !ok block scrubs them to the illegal pattern.
  always_comb begin
    ok      = 1'b0;
    d_cu    = 6'd0;
    d_alu   = ALU_NOP;
    d_imm   = 32'd0;
    d_rd    = 5'd0;
    d_rs1   = 5'd0;
    d_rs2   = 5'd0;
    d_shamt = 5'd0;
    d_pc    = 32'd4;
    d_ovr   = 2'b00;
    if (inst_q[1:0] == 2'b11) begin
      case (opc)
        OPC_LUI:   begin ok = 1'b1; d_cu = 6'd1; d_alu = ALU_PASSB; d_imm = imm_u; d_rd = inst_q[11:7]; end
        OPC_AUIPC: begin ok = 1'b1; d_cu = 6'd2; d_alu = ALU_ADD; d_imm = imm_u; d_rd = inst_q[11:7]; end
        OPC_JAL: begin
          ok = 1'b1; d_cu = 6'd3; d_alu = ALU_ADD; d_imm = imm_j; d_rd = inst_q[11:7];
          d_pc = imm_j; d_ovr = 2'b01;
        end
        OPC_JALR: begin
          ok = (f3 == 3'b000); d_cu = 6'd4; d_alu = ALU_ADD; d_imm = imm_i;
          d_rd = inst_q[11:7]; d_rs1 = inst_q[19:15]; d_ovr = 2'b01;
        end
        OPC_BRANCH: begin
          d_imm = imm_b; d_rs1 = inst_q[19:15]; d_rs2 = inst_q[24:20]; d_ovr = 2'b01;
          case (f3)
            3'b000:  begin ok = 1'b1; d_cu = 6'd5;  d_alu = ALU_EQ;  end
            3'b001:  begin ok = 1'b1; d_cu = 6'd6;  d_alu = ALU_NE;  end
            3'b100:  begin ok = 1'b1; d_cu = 6'd7;  d_alu = ALU_LT;  end
            3'b101:  begin ok = 1'b1; d_cu = 6'd8;  d_alu = ALU_GE;  end
            3'b110:  begin ok = 1'b1; d_cu = 6'd9;  d_alu = ALU_LTU; end
            3'b111:  begin ok = 1'b1; d_cu = 6'd10; d_alu = ALU_GEU; end
            default: ;
          endcase
        end
        OPC_LOAD: begin
          d_alu = ALU_ADD; d_imm = imm_i; d_rd = inst_q[11:7]; d_rs1 = inst_q[19:15]; d_ovr = 2'b10;
          case (f3)
            3'b000:  begin ok = 1'b1; d_cu = 6'd11; end
            3'b001:  begin ok = 1'b1; d_cu = 6'd12; end
            3'b010:  begin ok = 1'b1; d_cu = 6'd13; end
            3'b100:  begin ok = 1'b1; d_cu = 6'd14; end
            3'b101:  begin ok = 1'b1; d_cu = 6'd15; end
            default: ;
          endcase
        end
        OPC_STORE: begin
          d_alu = ALU_ADD; d_imm = imm_s; d_rs1 = inst_q[19:15]; d_rs2 = inst_q[24:20];
          case (f3)
            3'b000:  begin ok = 1'b1; d_cu = 6'd16; end
            3'b001:  begin ok = 1'b1; d_cu = 6'd17; end
            3'b010:  begin ok = 1'b1; d_cu = 6'd18; end
            default: ;
          endcase
        end
        OPC_OPIMM: begin
          d_imm = imm_i; d_rd = inst_q[11:7]; d_rs1 = inst_q[19:15];
          case (f3)
            3'b000: begin ok = 1'b1; d_cu = 6'd19; d_alu = ALU_ADD;  end
            3'b010: begin ok = 1'b1; d_cu = 6'd20; d_alu = ALU_SLT;  end
            3'b011: begin ok = 1'b1; d_cu = 6'd21; d_alu = ALU_SLTU; end
            3'b100: begin ok = 1'b1; d_cu = 6'd22; d_alu = ALU_XOR;  end
            3'b110: begin ok = 1'b1; d_cu = 6'd23; d_alu = ALU_OR;   end
            3'b111: begin ok = 1'b1; d_cu = 6'd24; d_alu = ALU_AND;  end
            3'b001: begin
              ok = (f7 == F7_BASE); d_cu = 6'd25; d_alu = ALU_SLL; d_shamt = inst_q[24:20];
            end
            default: begin
              d_shamt = inst_q[24:20];
              if (f7 == F7_BASE)     begin ok = 1'b1; d_cu = 6'd26; d_alu = ALU_SRL; end
              else if (f7 == F7_ALT) begin ok = 1'b1; d_cu = 6'd27; d_alu = ALU_SRA; end
            end
          endcase
        end
        OPC_OP: begin
          d_rd = inst_q[11:7]; d_rs1 = inst_q[19:15]; d_rs2 = inst_q[24:20];
          if (f7 == F7_BASE) begin
            ok = 1'b1;
            case (f3)
              3'b000:  begin d_cu = 6'd28; d_alu = ALU_ADD;  end
              3'b001:  begin d_cu = 6'd30; d_alu = ALU_SLL;  end
              3'b010:  begin d_cu = 6'd31; d_alu = ALU_SLT;  end
              3'b011:  begin d_cu = 6'd32; d_alu = ALU_SLTU; end
              3'b100:  begin d_cu = 6'd33; d_alu = ALU_XOR;  end
              3'b101:  begin d_cu = 6'd34; d_alu = ALU_SRL;  end
              3'b110:  begin d_cu = 6'd36; d_alu = ALU_OR;   end
              default: begin d_cu = 6'd37; d_alu = ALU_AND;  end
            endcase
          end else if (f7 == F7_ALT) begin
            if (f3 == 3'b000)      begin ok = 1'b1; d_cu = 6'd29; d_alu = ALU_SUB; end
            else if (f3 == 3'b101) begin ok = 1'b1; d_cu = 6'd35; d_alu = ALU_SRA; end
          end
        end
        OPC_FENCE: begin
          ok = 1'b1; d_cu = 6'd38; d_imm = imm_i; d_rd = inst_q[11:7]; d_rs1 = inst_q[19:15];
          d_ovr = 2'b11;
        end
        OPC_SYSTEM: begin
          d_ovr = 2'b11;
          if (inst_q == 32'h0000_0073)      begin ok = 1'b1; d_cu = 6'd39; end
          else if (inst_q == 32'h0010_0073) begin ok = 1'b1; d_cu = 6'd40; end
        end
        default: ;
      endcase
    end
    if (!ok) begin
      d_cu    = 6'd0;
      d_alu   = ALU_NOP;
      d_imm   = 32'd0;
      d_rd    = 5'd0;
      d_rs1   = 5'd0;
      d_rs2   = 5'd0;
      d_shamt = 5'd0;
      d_pc    = 32'd4;
      d_ovr   = 2'b11;
    end
  end

  always_ff @(posedge soc_clk) begin
    if (IDU_reset) begin
      inst_q              <= 32'd0;
      IDU_ready           <= 1'b0;
      Instruction_to_CU   <= 6'd0;
      Instruction_to_ALU  <= ALU_NOP;
      imm                 <= 32'd0;
      rd                  <= 5'd0;
      rs1                 <= 5'd0;
      rs2                 <= 5'd0;
      shamt               <= 5'd0;
      pc_increment        <= 32'd4;
      pipeline_override   <= 2'b00;
      invalid_instruction <= 1'b0;
    end else if (IDU_stall) begin
      IDU_ready <= 1'b0;
    end else begin
      IDU_ready <= (state == ST_PENDING);
      if (Fetch_ready) inst_q <= instruction;
      if (state == ST_PENDING) begin
        Instruction_to_CU   <= d_cu;
        Instruction_to_ALU  <= d_alu;
        imm                 <= d_imm;
        rd                  <= d_rd;
        rs1                 <= d_rs1;
        rs2                 <= d_rs2;
        shamt               <= d_shamt;
        pc_increment        <= d_pc;
        pipeline_override   <= d_ovr;
        invalid_instruction <= !ok;
      end
    end
  end

endmodule

// File: tb/tb_idu_top.sv
// Directed bench for idu_top: a decode vector table plus hand-built sequences for
// back-to-back issue, stall hold, and reset precedence.
module tb_idu_top;

  localparam int W = 99;

  logic        soc_clk = 1'b0;
  logic        IDU_reset, Fetch_ready, IDU_stall;
  logic [31:0] instruction;
  logic        IDU_ready;
  logic [5:0]  Instruction_to_CU;
  logic [4:0]  Instruction_to_ALU;
  logic [31:0] imm;
  logic [4:0]  rd, rs1, rs2, shamt;
  logic [31:0] pc_increment;
  logic [1:0]  pipeline_override;
  logic        invalid_instruction;
  logic        state_dbg;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [5:0]  cu;
    logic [4:0]  alu;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2, shamt;
    logic [31:0] pc;
    logic [1:0]  ovr;
    logic        inv;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  vec_t tv[$];
  vec_t bb[3];
  vec_t rst_v;

  idu_top dut (
    .soc_clk(soc_clk), .IDU_reset(IDU_reset), .Fetch_ready(Fetch_ready),
    .instruction(instruction), .IDU_stall(IDU_stall), .IDU_ready(IDU_ready),
    .Instruction_to_CU(Instruction_to_CU), .Instruction_to_ALU(Instruction_to_ALU),
    .imm(imm), .rd(rd), .rs1(rs1), .rs2(rs2), .shamt(shamt),
    .pc_increment(pc_increment), .pipeline_override(pipeline_override),
    .invalid_instruction(invalid_instruction), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 soc_clk = ~soc_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  function automatic vec_t mk(string n, logic [31:0] ins, int cu, int alu, logic [31:0] im,
                              int d, int s1, int s2, int sh, logic [31:0] pc, int ovr, int inv);
    vec_t v;
    v.name = n; v.instr = ins; v.cu = 6'(cu); v.alu = 5'(alu); v.imm = im;
    v.rd = 5'(d); v.rs1 = 5'(s1); v.rs2 = 5'(s2); v.shamt = 5'(sh);
    v.pc = pc; v.ovr = 2'(ovr); v.inv = 1'(inv);
    return v;
  endfunction

  function automatic vec_t bad_v(string n, logic [31:0] ins);
    return mk(n, ins, 0, 31, 32'd0, 0, 0, 0, 0, 32'd4, 3, 1);
  endfunction

  // scoreboard
  task automatic expect_out(vec_t v, logic rdy);
    exp_q.push_back({rdy, v.cu, v.alu, v.imm, v.rd, v.rs1, v.rs2, v.shamt, v.pc, v.ovr, v.inv});
  endtask

  task automatic check(string name);
    logic [W-1:0] a, e;
    a = {IDU_ready, Instruction_to_CU, Instruction_to_ALU, imm, rd, rs1, rs2, shamt,
         pc_increment, pipeline_override, invalid_instruction};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, got %h", name, a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got %h expected %h (rdy|cu|alu|imm|rd|rs1|rs2|sh|pc|ovr|inv)",
                 name, a, e);
      end
    end
  endtask

  task automatic check_bit(string name, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // driver: one strobe, then check the decode pulse on the following edge
  task automatic apply(vec_t v);
    @(negedge soc_clk);
    Fetch_ready = 1'b1;
    instruction = v.instr;
    @(negedge soc_clk);
    Fetch_ready = 1'b0;
    instruction = $urandom();
    @(posedge soc_clk);
    #1;
    expect_out(v, 1'b1);
    check(v.name);
  endtask

  initial begin
    rst_v = mk("reset", 32'd0, 0, 31, 32'd0, 0, 0, 0, 0, 32'd4, 0, 0);
    tv.push_back(mk("addi",     32'h00A00093, 19, 0,  32'd10,       1, 0, 0, 0, 32'd4, 0, 0));
    tv.push_back(mk("beq_neg",  32'hFE208EE3, 5,  10, 32'hFFFFFFFC, 0, 1, 2, 0, 32'd4, 1, 0));
    tv.push_back(mk("jal",      32'h008000EF, 3,  0,  32'd8,        1, 0, 0, 0, 32'd8, 1, 0));
    tv.push_back(mk("sra",      32'h40315233, 35, 7,  32'd0,        4, 2, 3, 0, 32'd4, 0, 0));
    tv.push_back(bad_v("all_ones", 32'hFFFFFFFF));
    tv.push_back(mk("lui",      32'h123452B7, 1,  16, 32'h12345000, 5, 0, 0, 0, 32'd4, 0, 0));
    tv.push_back(mk("lw_neg",   32'hFF812183, 13, 0,  32'hFFFFFFF8, 3, 2, 0, 0, 32'd4, 2, 0));
    tv.push_back(mk("sw",       32'h00532623, 18, 0,  32'd12,       0, 6, 5, 0, 32'd4, 0, 0));
    tv.push_back(mk("srai",     32'h40345393, 27, 7,  32'h00000403, 7, 8, 0, 3, 32'd4, 0, 0));
    tv.push_back(bad_v("slli_bit25", 32'h02109093));
    tv.push_back(mk("ecall",    32'h00000073, 39, 31, 32'd0,        0, 0, 0, 0, 32'd4, 3, 0));
    tv.push_back(mk("ebreak",   32'h00100073, 40, 31, 32'd0,        0, 0, 0, 0, 32'd4, 3, 0));
    tv.push_back(bad_v("system_other", 32'h00200073));
    tv.push_back(bad_v("jalr_f3", 32'h000010E7));
    tv.push_back(bad_v("branch_f3", 32'h00002063));
    tv.push_back(bad_v("compressed", 32'h00000001));
    tv.push_back(mk("bgeu",     32'h0020F863, 10, 15, 32'd16,       0, 1, 2, 0, 32'd4, 1, 0));
    tv.push_back(mk("sub",      32'h402081B3, 29, 1,  32'd0,        3, 1, 2, 0, 32'd4, 0, 0));
    tv.push_back(bad_v("and_f7", 32'h4020F1B3));
    tv.push_back(mk("fence",    32'h0FF0000F, 38, 31, 32'h000000FF, 0, 0, 0, 0, 32'd4, 3, 0));
    tv.push_back(mk("auipc",    32'hFFFFF117, 2,  0,  32'hFFFFF000, 2, 0, 0, 0, 32'd4, 0, 0));
    tv.push_back(bad_v("load_f3", 32'h00003003));
    tv.push_back(mk("sltiu",    32'hFFF13093, 21, 4,  32'hFFFFFFFF, 1, 2, 0, 0, 32'd4, 0, 0));
    bb[0] = tv[0];
    bb[1] = tv[1];
    bb[2] = tv[3];

    // reset state
    IDU_reset = 1'b1; Fetch_ready = 1'b0; IDU_stall = 1'b0; instruction = 32'd0;
    repeat (2) @(posedge soc_clk);
    #1;
    expect_out(rst_v, 1'b0);
    check("reset_state");
    check_bit("reset_fsm_idle", state_dbg, 1'b0);
    @(negedge soc_clk);
    IDU_reset = 1'b0;

    // decode table
    foreach (tv[i]) apply(tv[i]);
    @(posedge soc_clk);
    #1;
    expect_out(tv[tv.size()-1], 1'b0);
    check("ready_one_cycle_hold");

    // back-to-back strobes: one result per cycle
    for (int k = 0; k <= 3; k++) begin
      @(negedge soc_clk);
      Fetch_ready = (k < 3);
      if (k < 3) instruction = bb[k].instr;
      @(posedge soc_clk);
      #1;
      if (k > 0) begin
        expect_out(bb[k-1], 1'b1);
        check({"b2b_", bb[k-1].name});
      end
    end
    @(posedge soc_clk);
    #1;
    expect_out(bb[2], 1'b0);
    check("b2b_end");

    // stall after capture: hold, ignore strobes, then complete
    @(negedge soc_clk);
    Fetch_ready = 1'b1; instruction = tv[0].instr;
    @(negedge soc_clk);
    IDU_stall = 1'b1; instruction = tv[1].instr;
    for (int s = 0; s < 3; s++) begin
      @(posedge soc_clk);
      #1;
      expect_out(bb[2], 1'b0);
      check("stall_hold");
    end
    check_bit("stall_pending", state_dbg, 1'b1);
    @(negedge soc_clk);
    IDU_stall = 1'b0; Fetch_ready = 1'b0;
    @(posedge soc_clk);
    #1;
    expect_out(tv[0], 1'b1);
    check("stall_release_pulse");
    @(posedge soc_clk);
    #1;
    expect_out(tv[0], 1'b0);
    check("stall_no_extra");

    // reset beats pending decode, strobe and stall
    @(negedge soc_clk);
    Fetch_ready = 1'b1; instruction = tv[2].instr;
    @(negedge soc_clk);
    IDU_reset = 1'b1; IDU_stall = 1'b1; instruction = tv[1].instr;
    @(posedge soc_clk);
    #1;
    expect_out(rst_v, 1'b0);
    check("reset_with_fetch");
    @(negedge soc_clk);
    IDU_reset = 1'b0; IDU_stall = 1'b0; Fetch_ready = 1'b0;
    @(posedge soc_clk);
    #1;
    expect_out(rst_v, 1'b0);
    check("reset_discards_pending");
    apply(tv[10]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
